// File: rtl/mmio_coherence_bridge.sv
// MMIO front end that stages one 64 B line transaction and issues it on the
// coherence directory's GPU request/response channel.
module mmio_coherence_bridge #(
  parameter int          ADDR_WIDTH  = 64,
  parameter int          DATA_WIDTH  = 512,
  parameter logic [15:0] BASE        = 16'h0100,
  parameter logic [31:0] TIMEOUT_RST = 32'd1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             mmio_addr,
  input  logic                    mmio_wr_en,
  input  logic                    mmio_rd_en,
  input  logic [63:0]             mmio_wr_data,
  output logic [63:0]             mmio_rd_data,
  output logic                    mmio_rd_valid,
  output logic                    gpu_req_valid,
  input  logic                    gpu_req_ready,
  output logic                    gpu_req_write,
  output logic [ADDR_WIDTH-1:0]   gpu_req_addr,
  output logic [DATA_WIDTH-1:0]   gpu_req_data,
  output logic [DATA_WIDTH/8-1:0] gpu_req_strb,
  input  logic                    gpu_resp_valid,
  output logic                    gpu_resp_ready,
  input  logic [DATA_WIDTH-1:0]   gpu_resp_data,
  input  logic                    gpu_resp_error,
  output logic                    irq_done
);

  localparam int NW = DATA_WIDTH / 64;
  localparam int SW = DATA_WIDTH / 8;

  // Register word indices (byte offset from BASE divided by 8)
  localparam logic [12:0] IDX_ADDR    = 13'd0;
  localparam logic [12:0] IDX_DATA    = 13'd1;
  localparam logic [12:0] IDX_STRB    = 13'd9;
  localparam logic [12:0] IDX_CMD     = 13'd10;
  localparam logic [12:0] IDX_STATUS  = 13'd11;
  localparam logic [12:0] IDX_RDATA   = 13'd12;
  localparam logic [12:0] IDX_TIMEOUT = 13'd20;
  localparam logic [12:0] IDX_OPCOUNT = 13'd21;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [63:0]           data_reg [NW];
  logic [63:0]           rdata_reg [NW];
  logic [SW-1:0]         strb_reg;
  logic [31:0]           timeout_reg;
  logic [31:0]           cnt_reg;
  logic [63:0]           opcount_reg;
  logic                  write_reg, req_valid_reg, resp_ready_reg, irq_reg;
  logic                  sts_done, sts_err, sts_tmo, sts_mis, sts_ovr, sts_stale;
  logic [63:0]           rd_mux;

  // Address decode; only 8-byte aligned offsets above BASE can hit
  logic [15:0] off;
  logic [12:0] widx;
  logic        in_win, busy;
  logic        hit_addr, hit_strb, hit_cmd, hit_status, hit_timeout, hit_opcount;
  logic [NW-1:0] hit_data, hit_rdata;

  assign off         = mmio_addr[15:0] - BASE;
  assign widx        = off[15:3];
  assign in_win      = (mmio_addr[15:0] >= BASE) && (off[2:0] == 3'd0);
  assign hit_addr    = in_win && (widx == IDX_ADDR);
  assign hit_strb    = in_win && (widx == IDX_STRB);
  assign hit_cmd     = in_win && (widx == IDX_CMD);
  assign hit_status  = in_win && (widx == IDX_STATUS);
  assign hit_timeout = in_win && (widx == IDX_TIMEOUT);
  assign hit_opcount = in_win && (widx == IDX_OPCOUNT);
  assign busy        = (state == REQ) || (state == WAIT);

  genvar gi;
  generate
    for (gi = 0; gi < NW; gi++) begin : g_words
      assign hit_data[gi]                = in_win && (widx == IDX_DATA + 13'(gi));
      assign hit_rdata[gi]               = in_win && (widx == IDX_RDATA + 13'(gi));
      assign gpu_req_data[64*gi +: 64]   = data_reg[gi];
    end
  endgenerate

  logic stage_hit, wr_ok, sts_w1c, resp_fire;
  assign stage_hit = hit_addr | (|hit_data) | hit_strb | hit_cmd | hit_timeout;
  assign wr_ok     = mmio_wr_en && !busy;
  assign sts_w1c   = mmio_wr_en && hit_status;
  assign resp_fire = gpu_resp_valid && resp_ready_reg;

  // Staging registers: software writes accepted only while no transaction is in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg    <= '0;
      strb_reg    <= '0;
      timeout_reg <= TIMEOUT_RST;
      for (int i = 0; i < NW; i++) data_reg[i] <= '0;
    end else if (wr_ok) begin
      if (hit_addr)    addr_reg    <= mmio_wr_data[ADDR_WIDTH-1:0];
      if (hit_strb)    strb_reg    <= mmio_wr_data[SW-1:0];
      if (hit_timeout) timeout_reg <= mmio_wr_data[31:0];
      for (int i = 0; i < NW; i++)
        if (hit_data[i]) data_reg[i] <= mmio_wr_data;
    end
  end

  // Response line capture; only a response that completes the live transaction lands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NW; i++) rdata_reg[i] <= '0;
    end else if (resp_fire && state == WAIT) begin
      for (int i = 0; i < NW; i++) rdata_reg[i] <= gpu_resp_data[64*i +: 64];
    end
  end

  // Transaction FSM with status flags; hardware sets are written last so they beat W1C
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      req_valid_reg  <= 1'b0;
      resp_ready_reg <= 1'b0;
      write_reg      <= 1'b0;
      cnt_reg        <= '0;
      opcount_reg    <= '0;
      irq_reg        <= 1'b0;
      sts_done       <= 1'b0;
      sts_err        <= 1'b0;
      sts_tmo        <= 1'b0;
      sts_mis        <= 1'b0;
      sts_ovr        <= 1'b0;
      sts_stale      <= 1'b0;
    end else begin
      irq_reg <= 1'b0;
      if (sts_w1c) begin
        sts_done  <= sts_done  & ~mmio_wr_data[1];
        sts_err   <= sts_err   & ~mmio_wr_data[2];
        sts_tmo   <= sts_tmo   & ~mmio_wr_data[3];
        sts_mis   <= sts_mis   & ~mmio_wr_data[4];
        sts_ovr   <= sts_ovr   & ~mmio_wr_data[5];
        sts_stale <= sts_stale & ~mmio_wr_data[6];
      end
      if (mmio_wr_en && busy && stage_hit) sts_ovr   <= 1'b1;
      if (resp_fire && state != WAIT)      sts_stale <= 1'b1;

      unique case (state)
        IDLE: begin
          resp_ready_reg <= 1'b1;
          if (wr_ok && hit_cmd && mmio_wr_data[0]) begin
            if (addr_reg[5:0] != 6'd0) begin
              sts_mis <= 1'b1;
              irq_reg <= 1'b1;
            end else begin
              sts_done       <= 1'b0;
              sts_err        <= 1'b0;
              sts_tmo        <= 1'b0;
              sts_mis        <= 1'b0;
              write_reg      <= mmio_wr_data[1];
              req_valid_reg  <= 1'b1;
              resp_ready_reg <= 1'b0;
              state          <= REQ;
            end
          end
        end
        REQ: begin
          if (gpu_req_ready) begin
            req_valid_reg  <= 1'b0;
            resp_ready_reg <= 1'b1;
            cnt_reg        <= timeout_reg;
            state          <= WAIT;
          end
        end
        WAIT: begin
          if (gpu_resp_valid) begin
            sts_err     <= gpu_resp_error;
            sts_done    <= 1'b1;
            opcount_reg <= opcount_reg + 64'd1;
            irq_reg     <= 1'b1;
            state       <= DONE;
          end else if (cnt_reg != 32'd0) begin
            // A zero load never counts, which is what disables the timeout
            cnt_reg <= cnt_reg - 32'd1;
            if (cnt_reg == 32'd1) begin
              sts_tmo <= 1'b1;
              irq_reg <= 1'b1;
              state   <= DONE;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Read mux over the current (pre-write) register contents
  always_comb begin
    rd_mux = '0;
    if (hit_addr)    rd_mux = 64'(addr_reg);
    if (hit_strb)    rd_mux = 64'(strb_reg);
    if (hit_status)  rd_mux = {57'd0, sts_stale, sts_ovr, sts_mis, sts_tmo, sts_err, sts_done, busy};
    if (hit_timeout) rd_mux = 64'(timeout_reg);
    if (hit_opcount) rd_mux = opcount_reg;
    for (int i = 0; i < NW; i++) begin
      if (hit_data[i])  rd_mux = data_reg[i];
      if (hit_rdata[i]) rd_mux = rdata_reg[i];
    end
  end

  // Registered read return, one cycle after the strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mmio_rd_valid <= 1'b0;
      mmio_rd_data  <= '0;
    end else begin
      mmio_rd_valid <= mmio_rd_en;
      mmio_rd_data  <= mmio_rd_en ? rd_mux : 64'd0;
    end
  end

  assign gpu_req_valid  = req_valid_reg;
  assign gpu_req_write  = write_reg;
  assign gpu_req_addr   = addr_reg;
  assign gpu_req_strb   = strb_reg;
  assign gpu_resp_ready = resp_ready_reg;
  assign irq_done       = irq_reg;

endmodule

// File: tb/tb_mmio_coherence_bridge.sv
// Directed bench for mmio_coherence_bridge: register reads are checked by a
// scoreboard queue, channel and interrupt behaviour by inline assertions.
`timescale 1ns/1ps
module tb_mmio_coherence_bridge;

  localparam logic [15:0] BASE_T = 16'h0100;
  localparam logic [15:0] O_ADDR = 16'h00, O_DATA7 = 16'h40, O_STRB = 16'h48, O_CMD = 16'h50;
  localparam logic [15:0] O_STATUS = 16'h58, O_RDATA0 = 16'h60, O_TIMEOUT = 16'hA0, O_OPCOUNT = 16'hA8;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  mmio_addr;
  logic         mmio_wr_en, mmio_rd_en;
  logic [63:0]  mmio_wr_data, mmio_rd_data;
  logic         mmio_rd_valid;
  logic         gpu_req_valid, gpu_req_ready, gpu_req_write;
  logic [63:0]  gpu_req_addr;
  logic [511:0] gpu_req_data;
  logic [63:0]  gpu_req_strb;
  logic         gpu_resp_valid, gpu_resp_ready, gpu_resp_error;
  logic [511:0] gpu_resp_data;
  logic         irq_done;

  int errors = 0;
  int checks = 0;
  int irq_cnt = 0;
  int hs_cnt = 0;
  logic [63:0] exp_q[$];
  string       tag_q[$];

  mmio_coherence_bridge dut (
    .clk(clk), .rst(rst),
    .mmio_addr(mmio_addr), .mmio_wr_en(mmio_wr_en), .mmio_rd_en(mmio_rd_en),
    .mmio_wr_data(mmio_wr_data), .mmio_rd_data(mmio_rd_data), .mmio_rd_valid(mmio_rd_valid),
    .gpu_req_valid(gpu_req_valid), .gpu_req_ready(gpu_req_ready), .gpu_req_write(gpu_req_write),
    .gpu_req_addr(gpu_req_addr), .gpu_req_data(gpu_req_data), .gpu_req_strb(gpu_req_strb),
    .gpu_resp_valid(gpu_resp_valid), .gpu_resp_ready(gpu_resp_ready),
    .gpu_resp_data(gpu_resp_data), .gpu_resp_error(gpu_resp_error),
    .irq_done(irq_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (irq_done === 1'b1) irq_cnt++;
    if (gpu_req_valid === 1'b1 && gpu_req_ready === 1'b1) hs_cnt++;
  end

  // Scoreboard: each returned read pops the value queued when it was issued
  always @(negedge clk) begin
    logic [63:0] e;
    string       t;
    if (mmio_rd_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL rd_unexpected: observed data %h with no read outstanding", mmio_rd_data);
      end else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        assert (mmio_rd_data === e) else begin
          errors++;
          $error("FAIL %s: observed %h expected %h", t, mmio_rd_data, e);
        end
        $display("read %-14s data=%h", t, mmio_rd_data);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-14s obs=%h", tag, obs);
  endtask

  task automatic wr(input logic [15:0] off, input logic [63:0] d);
    mmio_addr = {16'h0, BASE_T + off};
    mmio_wr_data = d;
    mmio_wr_en = 1'b1;
    @(posedge clk); #1;
    mmio_wr_en = 1'b0;
    $display("write off=%h data=%h", off, d);
  endtask

  task automatic rd(input logic [15:0] off, input logic [63:0] e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    mmio_addr = {16'h0, BASE_T + off};
    mmio_rd_en = 1'b1;
    @(posedge clk); #1;
    mmio_rd_en = 1'b0;
  endtask

  task automatic respond(input logic [63:0] w0, input logic err);
    gpu_resp_data = '0;
    gpu_resp_data[63:0] = w0;
    gpu_resp_error = err;
    gpu_resp_valid = 1'b1;
    @(posedge clk); #1;
    gpu_resp_valid = 1'b0;
    gpu_resp_error = 1'b0;
  endtask

  task automatic wait_irq(input string tag, output int n);
    n = 0;
    while (irq_done !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, {63'd0, irq_done}, 64'd1);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (gpu_req_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, {63'd0, gpu_req_valid}, 64'd1);
  endtask

  initial begin
    int n;
    logic [511:0] exp_data;
    logic ok;

    rst = 1'b1;
    mmio_addr = '0; mmio_wr_en = 0; mmio_rd_en = 0; mmio_wr_data = '0;
    gpu_req_ready = 0; gpu_resp_valid = 0; gpu_resp_error = 0; gpu_resp_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_valid", {63'd0, gpu_req_valid}, 64'd0);
    check("rst_irq", {63'd0, irq_done}, 64'd0);
    check("rst_rd_valid", {63'd0, mmio_rd_valid}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    rd(O_TIMEOUT, 64'd1024, "rst_timeout");
    rd(O_STATUS, 64'd0, "rst_status");
    rd(O_OPCOUNT, 64'd0, "rst_opcount");
    rd(16'h00B0, 64'd0, "unmapped");

    // Read transaction
    irq_cnt = 0;
    gpu_req_ready = 1'b1;
    wr(O_ADDR, 64'h1000);
    wr(O_CMD, 64'h1);
    wait_req("rd_req_valid");
    check("rd_req_write", {63'd0, gpu_req_write}, 64'd0);
    check("rd_req_addr", gpu_req_addr, 64'h1000);
    @(posedge clk); #1;
    gpu_req_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    respond(64'hDEADBEEF, 1'b0);
    check("rd_irq", {63'd0, irq_done}, 64'd1);
    @(posedge clk); #1;
    rd(O_RDATA0, 64'hDEADBEEF, "rd_rdata0");
    rd(O_STATUS, 64'h02, "rd_status");
    rd(O_OPCOUNT, 64'd1, "rd_opcount");
    rd(O_CMD, 64'd0, "cmd_readback");
    check("rd_irq_count", 64'(irq_cnt), 64'd1);

    // Write with 10 cycles of backpressure
    wr(O_DATA7, 64'hA5);
    wr(O_STRB, 64'hFFFF_FFFF_FFFF_FFFF);
    wr(O_ADDR, 64'h2000);
    exp_data = '0;
    exp_data[511:448] = 64'hA5;
    hs_cnt = 0;
    wr(O_CMD, 64'h3);
    wait_req("wr_req_valid");
    for (int i = 0; i < 11; i++) begin
      if (i == 10) gpu_req_ready = 1'b1;
      ok = (gpu_req_valid === 1'b1) && (gpu_req_write === 1'b1) && (gpu_req_addr === 64'h2000) &&
           (gpu_req_strb === 64'hFFFF_FFFF_FFFF_FFFF) && (gpu_req_data === exp_data);
      check("wr_hold", {63'd0, ok}, 64'd1);
      @(posedge clk); #1;
    end
    gpu_req_ready = 1'b0;
    check("wr_req_dropped", {63'd0, gpu_req_valid}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    respond(64'h1111, 1'b0);
    wait_irq("wr_irq", n);
    @(posedge clk); #1;
    check("wr_handshakes", 64'(hs_cnt), 64'd1);
    rd(O_STATUS, 64'h02, "wr_status");
    rd(O_RDATA0, 64'h1111, "wr_rdata0");

    // Misaligned GO
    wr(O_STATUS, 64'h7E);
    gpu_req_ready = 1'b1;
    hs_cnt = 0;
    wr(O_ADDR, 64'h1004);
    wr(O_CMD, 64'h1);
    check("mis_irq", {63'd0, irq_done}, 64'd1);
    check("mis_no_req", {63'd0, gpu_req_valid}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("mis_no_hs", 64'(hs_cnt), 64'd0);
    rd(O_STATUS, 64'h10, "mis_status");
    wr(O_STATUS, 64'h10);

    // Timeout after exactly 20 WAIT cycles, then a stale response
    wr(O_TIMEOUT, 64'd20);
    wr(O_ADDR, 64'h3000);
    wr(O_CMD, 64'h1);
    wait_req("tmo_req_valid");
    @(posedge clk); #1;
    gpu_req_ready = 1'b0;
    wait_irq("tmo_irq", n);
    check("tmo_cycles", 64'(n), 64'd20);
    @(posedge clk); #1;
    rd(O_STATUS, 64'h08, "tmo_status");
    respond(64'h9999, 1'b0);
    rd(O_STATUS, 64'h48, "stale_status");
    rd(O_RDATA0, 64'h1111, "tmo_rdata0");
    rd(O_OPCOUNT, 64'd2, "tmo_opcount");
    wr(O_STATUS, 64'h78);
    rd(O_STATUS, 64'h00, "w1c_status");

    // Overrun while busy, timeout disabled, error response racing a DONE W1C
    wr(O_TIMEOUT, 64'd0);
    wr(O_ADDR, 64'h4000);
    wr(O_CMD, 64'h1);
    wait_req("ovr_req_valid");
    wr(O_ADDR, 64'h5000);
    rd(O_STATUS, 64'h21, "ovr_busy_status");
    check("ovr_req_addr", gpu_req_addr, 64'h4000);
    gpu_req_ready = 1'b1;
    @(posedge clk); #1;
    gpu_req_ready = 1'b0;
    irq_cnt = 0;
    repeat (30) @(posedge clk);
    #1;
    check("no_tmo_irq", 64'(irq_cnt), 64'd0);
    gpu_resp_data = '0;
    gpu_resp_data[63:0] = 64'h2222;
    gpu_resp_error = 1'b1;
    gpu_resp_valid = 1'b1;
    mmio_addr = {16'h0, BASE_T + O_STATUS};
    mmio_wr_data = 64'h02;
    mmio_wr_en = 1'b1;
    @(posedge clk); #1;
    gpu_resp_valid = 1'b0;
    gpu_resp_error = 1'b0;
    mmio_wr_en = 1'b0;
    check("err_irq", {63'd0, irq_done}, 64'd1);
    @(posedge clk); #1;
    rd(O_STATUS, 64'h26, "err_status");
    rd(O_ADDR, 64'h4000, "ovr_addr_kept");
    rd(O_RDATA0, 64'h2222, "err_rdata0");
    rd(O_OPCOUNT, 64'd3, "err_opcount");
    // Same-cycle read and write: read returns the old value
    exp_q.push_back(64'h4000);
    tag_q.push_back("rw_same_old");
    mmio_addr = {16'h0, BASE_T + O_ADDR};
    mmio_wr_data = 64'h6000;
    mmio_rd_en = 1'b1;
    mmio_wr_en = 1'b1;
    @(posedge clk); #1;
    mmio_rd_en = 1'b0;
    mmio_wr_en = 1'b0;
    rd(O_ADDR, 64'h6000, "rw_same_new");

    // Reset during WAIT, stale response after reset, then a fresh transaction
    wr(O_STATUS, 64'h7E);
    wr(O_ADDR, 64'h7000);
    gpu_req_ready = 1'b1;
    wr(O_CMD, 64'h1);
    wait_req("rst_req_valid2");
    @(posedge clk); #1;
    gpu_req_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_req_valid", {63'd0, gpu_req_valid}, 64'd0);
    check("mid_rst_req_addr", gpu_req_addr, 64'd0);
    check("mid_rst_irq", {63'd0, irq_done}, 64'd0);
    check("mid_rst_rd_data", mmio_rd_data, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    rd(O_TIMEOUT, 64'd1024, "post_rst_timeout");
    rd(O_STATUS, 64'h00, "post_rst_status");
    respond(64'h7777, 1'b0);
    rd(O_STATUS, 64'h40, "post_rst_stale");
    rd(O_OPCOUNT, 64'd0, "post_rst_opcount");
    wr(O_ADDR, 64'h8000);
    gpu_req_ready = 1'b1;
    wr(O_CMD, 64'h1);
    wait_req("fresh_req_valid");
    check("fresh_req_addr", gpu_req_addr, 64'h8000);
    @(posedge clk); #1;
    gpu_req_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    respond(64'h3333, 1'b0);
    wait_irq("fresh_irq", n);
    @(posedge clk); #1;
    rd(O_RDATA0, 64'h3333, "fresh_rdata0");
    rd(O_STATUS, 64'h42, "fresh_status");
    rd(O_OPCOUNT, 64'd1, "fresh_opcount");

    repeat (2) @(posedge clk);
    #1;
    check("reads_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmio_coherence_bridge.md
Name: mmio_coherence_bridge

Overview:
- Host-facing front end that turns MMIO register accesses into single-line (64 B) read/write transactions on the coherence directory's GPU request/response channel.
- Sits between the host MMIO port and the directory's gpu_req/gpu_resp interface, directly upstream of the directory.
- Software stages address, data and byte strobes, rings a doorbell, then polls status or takes an interrupt and reads back the returned line.

Parameters:
- ADDR_WIDTH, 64, request address width.
- DATA_WIDTH, 512, line width; must be a multiple of 64; NW = DATA_WIDTH/64 data words (8).
- BASE, 16'h0100, register-window base offset on mmio_addr[15:0].
- TIMEOUT_RST, 32'd1024, reset value of the TIMEOUT register, in cycles.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- mmio_addr  in  32  byte address; only [15:0] decoded.
- mmio_wr_en  in  1  write strobe.
- mmio_rd_en  in  1  read strobe.
- mmio_wr_data  in  64  write data.
- mmio_rd_data  out  64  read data, registered.
- mmio_rd_valid  out  1  read data valid, one cycle after mmio_rd_en.
- gpu_req_valid  out  1  request valid.
- gpu_req_ready  in  1  directory accepts request.
- gpu_req_write  out  1  1 = write, 0 = read.
- gpu_req_addr  out  ADDR_WIDTH  line address.
- gpu_req_data  out  DATA_WIDTH  write data.
- gpu_req_strb  out  DATA_WIDTH/8  byte enables.
- gpu_resp_valid  in  1  response valid.
- gpu_resp_ready  out  1  response accept.
- gpu_resp_data  in  DATA_WIDTH  read data.
- gpu_resp_error  in  1  directory error flag.
- irq_done  out  1  one-cycle pulse on completion, error or timeout.

Behaviour:
- Register map (offsets from BASE, 64-bit each):
  - 0x00 ADDR.
  - 0x08+8i DATA[i], i = 0..NW-1.
  - 0x48 STRB.
  - 0x50 CMD: write-only; bit0 GO, bit1 WRITE.
  - 0x58 STATUS: bits [0] BUSY, [1] DONE, [2] ERR, [3] TMO, [4] MISALIGN, [5] OVR, [6] STALE. Bits 1-6 are sticky and cleared by writing 1 (W1C). BUSY is read-only.
  - 0x60+8i RDATA[i], read-only.
  - 0xA0 TIMEOUT, [31:0].
  - 0xA8 OPCOUNT, completed transactions, read-only, wraps.
- Unmapped reads return 0; unmapped writes are ignored.
- Reset values: all registers 0 except TIMEOUT = TIMEOUT_RST. All outputs 0, FSM in IDLE.
- Read path:
  - mmio_rd_data and mmio_rd_valid are registered, latency exactly 1 cycle.
  - A read and a write in the same cycle are both serviced; the read returns the pre-write value.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE, CMD write with GO=1: if ADDR[5:0] != 0, set MISALIGN, pulse irq_done, stay in IDLE, no request issued. Otherwise clear DONE/ERR/TMO/MISALIGN, latch WRITE, go to REQ.
  - REQ: gpu_req_valid = 1. Request fields are driven from the staging registers and held stable until gpu_req_ready. On ready, load the timeout counter with TIMEOUT and go to WAIT. No timeout in REQ.
  - WAIT: gpu_resp_ready = 1. On gpu_resp_valid:
    - capture gpu_resp_data into RDATA (for writes too);
    - ERR = gpu_resp_error, DONE = 1;
    - OPCOUNT += 1;
    - go to DONE.
    Otherwise the counter decrements; when it reaches 0, set TMO and go to DONE with RDATA unchanged. TIMEOUT = 0 disables the timeout.
  - DONE: pulse irq_done for 1 cycle, return to IDLE.
- BUSY = 1 in REQ and WAIT.
- While BUSY, writes to ADDR/DATA/STRB/CMD/TIMEOUT are dropped and set OVR. STATUS W1C and all reads still work.
- gpu_resp_ready = 1 in IDLE, WAIT and DONE; 0 in REQ.
  - A response accepted outside WAIT (late response after a timeout) is discarded and sets STALE.
  - A response in the same cycle the timeout expires: the response wins; TMO stays 0.
- A W1C of DONE in the same cycle DONE is set by hardware: the set wins.
- Asynchronous reset mid-transaction: FSM returns to IDLE immediately and gpu_req_valid deasserts. An in-flight response arriving after reset sets STALE.

Test Plan:
- Read: ADDR = 0x1000, CMD = 0x1; directory returns data word0 = 0xDEADBEEF after 5 cycles → gpu_req_write = 0, gpu_req_addr = 0x1000; RDATA[0] = 0xDEADBEEF, STATUS = 0x02, OPCOUNT = 1, one irq_done pulse.
- Write with backpressure: DATA[7] = 0xA5, STRB = all-ones, CMD = 0x3, gpu_req_ready held low 10 cycles → gpu_req_* stable for all 11 cycles, exactly one handshake, STATUS DONE = 1.
- Misaligned: ADDR = 0x1004, CMD = 0x1 → no gpu_req_valid, STATUS = 0x10, irq_done pulses.
- Timeout and stale: TIMEOUT = 20, no response → TMO = 1 after 20 WAIT cycles; a response injected later → STALE = 1; writing 0x78 to STATUS → STATUS = 0.
- Overrun and error: ADDR written while BUSY → OVR = 1, ADDR unchanged; response with gpu_resp_error = 1 → ERR = 1, DONE = 1.
- Reset during WAIT → all outputs 0, TIMEOUT = 1024, next GO issues a fresh request normally.
